// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared next-PC operation codes and default vectors for the
//               KGP-RISC program-counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam logic [3:0] PC_SEQ    = 4'd0;
    localparam logic [3:0] PC_JUMP   = 4'd1;
    localparam logic [3:0] PC_JREG   = 4'd2;
    localparam logic [3:0] PC_BRANCH = 4'd3;
    localparam logic [3:0] PC_CALL   = 4'd4;
    localparam logic [3:0] PC_RET    = 4'd5;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0080;

endpackage

`default_nettype wire

// File: rtl/return_addr_stack.sv
// ============================================================================
// Module      : return_addr_stack
// Description : Circular LIFO of return addresses with saturating count and
//               registered overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module return_addr_stack
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [XLEN-1:0]                din,
    output logic [XLEN-1:0]                dout,
    output logic [$clog2(RAS_DEPTH):0]     count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int c_PTR_W = $clog2(RAS_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [XLEN-1:0]    r_mem [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;
    logic [c_PTR_W-1:0] w_top_idx;
    logic               w_full;
    logic               w_empty;

    // r_ptr names the next free slot; when full it also names the oldest entry,
    // so a push there discards the oldest address without extra bookkeeping.
    assign w_top_idx = r_ptr - c_PTR_W'(1);
    assign w_full    = (r_count == c_CNT_W'(RAS_DEPTH));
    assign w_empty   = (r_count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (push) begin
                r_ptr      <= r_ptr + c_PTR_W'(1);
                r_overflow <= w_full;
                if (!w_full) begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_ptr   <= w_top_idx;
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    assign dout      = r_mem[w_top_idx];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Width-generic fetch-stage program counter with stall,
//               branches, call/return via a return-address stack, and traps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              JADDR_W      = 26,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        trap,
    input  logic [3:0]                  pc_control,
    input  logic [JADDR_W-1:0]          jump_address,
    input  logic [XLEN-1:0]             reg_address,
    output logic [XLEN-1:0]             pc,
    output logic [XLEN-1:0]             pc_plus4,
    output logic [XLEN-1:0]             epc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_jtgt;
    logic [XLEN-1:0] w_br_off;
    logic [XLEN-1:0] w_reg_tgt;
    logic [XLEN-1:0] w_ras_dout;
    logic [XLEN-1:0] w_next_pc;
    logic            w_advance;
    logic            w_push;
    logic            w_pop;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_reg_tgt  = reg_address & ~XLEN'(3);
    assign w_br_off   = XLEN'($signed(jump_address)) << 2;

    if (JADDR_W + 2 < XLEN) begin : g_jtgt_upper
        assign w_jtgt = {w_pc_plus4[XLEN-1:JADDR_W+2], jump_address, 2'b00};
    end else begin : g_jtgt_full
        assign w_jtgt = {jump_address, 2'b00};
    end

    // Only an unstalled, untrapped, non-reset cycle may touch the RAS.
    assign w_advance = !rst && !trap && !stall;
    assign w_push    = w_advance && (pc_control == PC_CALL);
    assign w_pop     = w_advance && (pc_control == PC_RET);

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .din       (w_pc_plus4),
        .dout      (w_ras_dout),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (pc_control)
            PC_JUMP:   w_next_pc = w_jtgt;
            PC_JREG:   w_next_pc = w_reg_tgt;
            PC_BRANCH: w_next_pc = w_pc_plus4 + w_br_off;
            PC_CALL:   w_next_pc = w_jtgt;
            PC_RET:    w_next_pc = (ras_count != '0) ? w_ras_dout : w_reg_tgt;
            default:   w_next_pc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_VECTOR;
            r_epc <= '0;
        end else if (trap) begin
            r_pc  <= TRAP_VECTOR;
            r_epc <= r_pc;
        end else if (!stall) begin
            r_pc  <= w_next_pc;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign epc      = r_epc;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer against a queue-based
//               reference model; directed scenarios then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic [3:0]  pc_control = 4'd0;
    logic [25:0] jump_address = '0;
    logic [31:0] reg_address = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_epc = 32'h0;
    logic [31:0] m_ras[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .trap          (trap),
        .pc_control    (pc_control),
        .jump_address  (jump_address),
        .reg_address   (reg_address),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic t, input logic s,
                                input logic [3:0] op, input logic [25:0] ja,
                                input logic [31:0] ra);
        logic [31:0] pp4;
        logic [31:0] jt;
        int          off;
        pp4   = m_pc + 32'd4;
        jt    = (pp4 & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (r) begin
            m_pc  = 32'h0;
            m_epc = 32'h0;
            m_ras.delete();
        end else if (t) begin
            m_epc = m_pc;
            m_pc  = 32'h80;
        end else if (!s) begin
            case (op)
                4'd1: m_pc = jt;
                4'd2: m_pc = {ra[31:2], 2'b00};
                4'd3: begin
                    off  = ja[25] ? int'({6'd0, ja}) - (1 << 26) : int'({6'd0, ja});
                    m_pc = pp4 + 32'(off * 4);
                end
                4'd4: begin
                    m_ras.push_back(pp4);
                    if (m_ras.size() > 4) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_pc = jt;
                end
                4'd5: begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back();
                    end else begin
                        m_pc  = {ra[31:2], 2'b00};
                        m_unf = 1'b1;
                    end
                end
                default: m_pc = pp4;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic t, input logic s,
                        input logic [3:0] op, input logic [25:0] ja,
                        input logic [31:0] ra);
        @(negedge clk);
        rst = r; trap = t; stall = s; pc_control = op;
        jump_address = ja; reg_address = ra;
        model_update(r, t, s, op, ja, ra);
        @(posedge clk);
        #1;
        check("pc",            pc,                  m_pc);
        check("pc_plus4",      pc_plus4,            m_pc + 32'd4);
        check("epc",           epc,                 m_epc);
        check("ras_count",     {29'd0, ras_count},  32'(m_ras.size()));
        check("ras_overflow",  {31'd0, ras_overflow},  {31'd0, m_ovf});
        check("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_unf});
    endtask

    initial begin
        // 1: reset, then sequential fetch
        step(1, 0, 0, 4'd0, 26'd0, 32'd0);
        check("reset_pc", pc, 32'h0);
        step(0, 0, 0, 4'd0, 26'd0, 32'd0);
        step(0, 0, 0, 4'd0, 26'd0, 32'd0);
        step(0, 0, 0, 4'd0, 26'd0, 32'd0);
        check("seq_pc", pc, 32'hC);

        // 2: jump, register jump, backward branch
        step(0, 0, 0, 4'd1, 26'd5, 32'd0);
        check("jump_pc", pc, 32'h14);
        step(0, 0, 0, 4'd2, 26'd0, 32'd31);
        check("jreg_pc", pc, 32'h1C);
        step(0, 0, 0, 4'd3, 26'h3FF_FFFE, 32'd0);
        check("branch_pc", pc, 32'h18);

        // 3: call then return
        step(0, 0, 0, 4'd4, 26'h40, 32'd0);
        check("call_pc", pc, 32'h100);
        step(0, 0, 0, 4'd5, 26'd0, 32'd0);
        check("ret_pc", pc, 32'h1C);

        // 4: overflow on fifth call, underflow on fifth return
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'd4, 26'h40 + 26'(i * 8), 32'd0);
        check("ovf_count", {29'd0, ras_count}, 32'd4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 4'd5, 26'd0, 32'h123);
        check("unf_pc", pc, 32'h120);

        // 5: stalled call is ignored; trap wins over stall
        step(0, 0, 0, 4'd4, 26'h10, 32'd0);
        step(0, 0, 1, 4'd4, 26'h20, 32'd0);
        check("stall_pc", pc, 32'h40);
        step(1, 0, 0, 4'd0, 26'd0, 32'd0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 4'd0, 26'd0, 32'd0);
        step(0, 1, 1, 4'd4, 26'h7, 32'd0);
        check("trap_pc", pc, 32'h80);
        check("trap_epc", epc, 32'h24);

        // 6: reset discards RAS contents
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'd4, 26'h40, 32'd0);
        step(1, 0, 0, 4'd4, 26'h40, 32'd0);
        check("rst_count", {29'd0, ras_count}, 32'd0);
        step(0, 0, 0, 4'd5, 26'd0, 32'h47);
        check("rst_unf", {31'd0, ras_underflow}, 32'd1);
        check("rst_unf_pc", pc, 32'h44);

        // Random traffic, biased toward call/return
        for (int i = 0; i < 400; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(4, 5));
            step(($urandom_range(0, 60) == 0), ($urandom_range(0, 20) == 0),
                 ($urandom_range(0, 5) == 0), op, 26'($urandom), 32'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program counter for the KGP-RISC fetch stage. It replaces the fixed 32-bit PC with a width-generic sequencer that adds a pipeline stall, PC-relative branches, call/return through an internal return-address stack (RAS), and a trap redirect that captures the exception PC. It sits between the decoder/control unit, which drives `pc_control`, and instruction memory, which consumes `pc`.

## Interface

Parameters:
- `XLEN`, 32: PC and register-address width.
- `JADDR_W`, 26: jump-address field width. Requires `JADDR_W + 2 <= XLEN`.
- `RAS_DEPTH`, 4: number of return-address entries. Power of two, at least 2.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0080: PC value loaded on a trap.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold all state this cycle.
- `trap`  in  1: redirect to `TRAP_VECTOR`.
- `pc_control`  in  4: next-PC operation code (see Operation).
- `jump_address`  in  `JADDR_W`: word target for JUMP/CALL; signed word offset for BRANCH.
- `reg_address`  in  `XLEN`: register target for JREG; fallback target for RET on an empty RAS.
- `pc`  out  `XLEN`: current PC, registered.
- `pc_plus4`  out  `XLEN`: `pc + 4`, combinational.
- `epc`  out  `XLEN`: PC captured at the last trap, registered.
- `ras_count`  out  `$clog2(RAS_DEPTH)+1`: number of valid RAS entries.
- `ras_overflow`  out  1: one-cycle pulse when a push discards the oldest entry.
- `ras_underflow`  out  1: one-cycle pulse when RET executes on an empty RAS.

## Operation

- Priority, highest first: `rst` > `trap` > `stall` > `pc_control`.
- Reset: `pc` = `RESET_VECTOR`; `epc`, `ras_count`, `ras_overflow`, `ras_underflow` = 0; RAS pointer = 0. Reset asserted mid-operation discards all RAS contents.
- Trap: `pc` = `TRAP_VECTOR`; `epc` = current `pc`. The RAS is unchanged. `stall` and `pc_control` are ignored.
- Stall: `pc`, `epc` and the RAS hold their values. Both flags are 0.
- `jtgt` = {`pc_plus4[XLEN-1:JADDR_W+2]`, `jump_address`, 2'b00}.
- `pc_control` encodings:
  - 0 SEQ: `pc` = `pc_plus4`.
  - 1 JUMP: `pc` = `jtgt`.
  - 2 JREG: `pc` = `reg_address` with bits [1:0] forced to 0.
  - 3 BRANCH: `pc` = `pc_plus4` + (sign-extended `jump_address` << 2), taken modulo 2^XLEN.
  - 4 CALL: push `pc_plus4` onto the RAS; `pc` = `jtgt`.
  - 5 RET with `ras_count` > 0: pop the RAS; `pc` = popped value.
  - 5 RET with `ras_count` = 0: `pc` = `reg_address` & ~3; `ras_underflow` pulses.
  - 6–15: reserved; treated as SEQ.
- RAS is a circular LIFO.
  - Push when `ras_count` = `RAS_DEPTH`: overwrite the oldest entry; `ras_count` stays at `RAS_DEPTH`; `ras_overflow` pulses.
- All arithmetic wraps at `XLEN` bits. No overflow detection on the PC itself.

## Timing

- One-cycle latency: inputs sampled at edge N take effect on `pc` after edge N.
- `pc_plus4` follows `pc` combinationally in the same cycle.
- `ras_overflow` and `ras_underflow` are registered. Each is high for exactly the one cycle following the causing edge, and 0 otherwise.
- Back-to-back CALL/RET on consecutive cycles is supported. A RET immediately after a CALL returns that CALL's `pc_plus4`.
- `trap` and `stall` asserted together: the trap is taken and `epc` captures the stalled `pc`.

## Structure

- Shared package `pc_pkg`:
  - `pc_control` encodings as named constants (`PC_SEQ`, `PC_JUMP`, `PC_JREG`, `PC_BRANCH`, `PC_CALL`, `PC_RET`).
  - Default `RESET_VECTOR` and `TRAP_VECTOR`.
- Sub-module `return_addr_stack`:
  - Parameters: `XLEN`, `RAS_DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `count`, `overflow`, `underflow`.
  - Contains the circular pointer and saturating count.
- The top level holds the PC and `epc` registers, the next-PC mux and the priority logic.

## Test plan

All scenarios use default parameters.

1. Reset then SEQ for 3 cycles → `pc` = 0x0, 0x4, 0x8, 0xC; all flags 0.
2. From `pc`=0xC: JUMP with `jump_address`=5 → 0x14. Then JREG with `reg_address`=31 → 0x1C. Then BRANCH with `jump_address`=26'h3FFFFFE → 0x18.
3. From `pc`=0x18: CALL with `jump_address`=0x40 → `pc`=0x100, `ras_count`=1. Then RET → `pc`=0x1C, `ras_count`=0.
4. Five CALLs back to back → `ras_overflow` pulses only after the 5th; `ras_count`=4. Five RETs → the first four return in LIFO order; the 5th pulses `ras_underflow` and loads `reg_address`&~3.
5. `stall`=1 with CALL → `pc` and `ras_count` unchanged. `stall`=1 with `trap`=1 at `pc`=0x24 → `pc`=0x80, `epc`=0x24.
6. `rst` pulsed with `ras_count`=3 and `pc`=0x100 → next cycle `pc`=0x0, `ras_count`=0; a following RET underflows.
